// File: rtl/y_wave_pkg.sv
// Shared definitions for the y_wave video blocks.
//   - FSM state codes for the packet source
//   - Avalon-ST Video packet type nibbles and the interlace nibble
//   - symbol width and the colour-bar lookup
package y_wave_pkg;

    localparam int unsigned SYM_W = 8;

    localparam logic [3:0] PKT_CTRL       = 4'hF;
    localparam logic [3:0] PKT_VID        = 4'h0;
    localparam logic [3:0] INTERLACE_PROG = 4'h3;

    // State register holds the beat that will be loaded on the next free slot.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_C_HDR = 3'd1;
    localparam state_t ST_C_D1  = 3'd2;
    localparam state_t ST_C_D2  = 3'd3;
    localparam state_t ST_C_D3  = 3'd4;
    localparam state_t ST_V_HDR = 3'd5;
    localparam state_t ST_V_PIX = 3'd6;

    // Eight vertical bars, left to right; symbol 2 is the top byte.
    function automatic logic [3*SYM_W-1:0] bar_colour(input logic [2:0] idx);
        logic [3*SYM_W-1:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF; // white
            3'd1:    c = 24'hFFFF00; // yellow
            3'd2:    c = 24'h00FFFF; // cyan
            3'd3:    c = 24'h00FF00; // green
            3'd4:    c = 24'hFF00FF; // magenta
            3'd5:    c = 24'hFF0000; // red
            3'd6:    c = 24'h0000FF; // blue
            default: c = 24'h000000; // black
        endcase
        return c;
    endfunction

    // Control-packet beat: one nibble per symbol in bits [3:0], upper nibble zero.
    function automatic logic [3*SYM_W-1:0] nib_beat(input logic [3:0] s2, input logic [3:0] s1,
                                                    input logic [3:0] s0);
        return {4'h0, s2, 4'h0, s1, 4'h0, s0};
    endfunction

endpackage

// File: rtl/y_pattern_tx_if.sv
// Avalon-ST Video stream bundle.
//   data  : beat data, symbol 0 in [7:0]
//   valid : beat valid (source)
//   ready : sink ready
//   sop   : first beat of a packet
//   eop   : last beat of a packet
interface y_pattern_tx_if #(
    parameter int unsigned DATA_W = 24
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;

    modport master (output data, output valid, output sop, output eop, input ready);
    modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/y_pattern_gen.sv
// Combinational test-pattern pixel generator.
//   x_lo, y_lo : low 8 bits of the raster position
//   sel        : 0 flat grey, 1 horizontal ramp, 2 vertical ramp, 3 colour bars
//   pixel      : 3-symbol pixel
module y_pattern_gen
    import y_wave_pkg::*;
(
    input  logic [7:0]         x_lo,
    input  logic [7:0]         y_lo,
    input  logic [1:0]         sel,
    output logic [3*SYM_W-1:0] pixel
);

    always_comb begin
        pixel = '0;
        case (sel)
            2'd0:    pixel = {3{8'h80}};
            2'd1:    pixel = {3{x_lo}};
            2'd2:    pixel = {3{y_lo}};
            default: pixel = bar_colour(x_lo[7:5]); // 32-pixel-wide bars
        endcase
    end

endmodule

// File: rtl/y_pattern_tx.sv
// Avalon-ST Video packet source: per frame, one control packet (width/height) followed by
// one video packet of generated test pixels, with sop/eop framing and ready back-pressure.
//   clk, rst           : clock, synchronous active-high reset
//   enable             : run frames continuously; low stops after the current frame
//   pattern_sel        : pixel pattern, latched at frame start
//   control_in_data    : [11:0] width, [23:12] height, [35:24] ignored
//   control_in_valid   : strobe loading the pending dimensions
//   video_out          : stream master (data/valid/sop/eop out, ready in)
//   frame_done         : 1-cycle pulse after the last pixel beat is accepted
module y_pattern_tx
    import y_wave_pkg::*;
#(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned DIM_W      = 12,
    parameter int unsigned DEF_WIDTH  = 256,
    parameter int unsigned DEF_HEIGHT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [35:0]           control_in_data,
    input  logic                  control_in_valid,
    y_pattern_tx_if.master        video_out,
    output logic                  frame_done
);

    localparam logic [DIM_W-1:0] DEF_W = DIM_W'(DEF_WIDTH);
    localparam logic [DIM_W-1:0] DEF_H = DIM_W'(DEF_HEIGHT);

    state_t             state;
    logic [DIM_W-1:0]   pend_w, pend_h, act_w, act_h;
    logic [DIM_W-1:0]   x, y;
    logic [1:0]         act_sel;
    logic               last_out;   // the beat currently held is the frame's last pixel
    logic [DATA_W-1:0]  out_data;
    logic               out_valid, out_sop, out_eop;

    logic               load, latch, x_last, y_last;
    logic [15:0]        w16, h16;
    logic [3*SYM_W-1:0] pixel;
    logic               unused_ctrl;

    assign unused_ctrl = ^control_in_data[35:24];

    assign video_out.data  = out_data;
    assign video_out.valid = out_valid;
    assign video_out.sop   = out_sop;
    assign video_out.eop   = out_eop;

    assign load   = !out_valid || video_out.ready;
    // Frame parameters are captured on leaving IDLE or on the slot after the last pixel goes.
    assign latch  = enable && ((state == ST_IDLE) || (state == ST_V_PIX && load && last_out));
    assign x_last = (x == act_w - DIM_W'(1));
    assign y_last = (y == act_h - DIM_W'(1));
    assign w16    = 16'(act_w);
    assign h16    = 16'(act_h);

    function automatic logic [DIM_W-1:0] or_def(input logic [DIM_W-1:0] v,
                                               input logic [DIM_W-1:0] d);
        return (v == '0) ? d : v;
    endfunction

    y_pattern_gen u_gen (
        .x_lo  (x[7:0]),
        .y_lo  (y[7:0]),
        .sel   (act_sel),
        .pixel (pixel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pend_w     <= DEF_W;
            pend_h     <= DEF_H;
            act_w      <= DEF_W;
            act_h      <= DEF_H;
            act_sel    <= 2'd0;
            x          <= '0;
            y          <= '0;
            last_out   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (control_in_valid) begin
                pend_w <= control_in_data[DIM_W-1:0];
                pend_h <= control_in_data[12 +: DIM_W];
            end
            if (latch) begin
                act_w   <= or_def(pend_w, DEF_W);
                act_h   <= or_def(pend_h, DEF_H);
                act_sel <= pattern_sel;
            end
            if (load) begin
                case (state)
                    ST_IDLE: begin
                        if (enable) state <= ST_C_HDR;
                    end
                    ST_C_HDR: begin
                        out_valid <= 1'b1;
                        out_data  <= DATA_W'(nib_beat(4'h0, 4'h0, PKT_CTRL));
                        out_sop   <= 1'b1;
                        out_eop   <= 1'b0;
                        state     <= ST_C_D1;
                    end
                    ST_C_D1: begin
                        out_data <= DATA_W'(nib_beat(w16[7:4], w16[11:8], w16[15:12]));
                        out_sop  <= 1'b0;
                        state    <= ST_C_D2;
                    end
                    ST_C_D2: begin
                        out_data <= DATA_W'(nib_beat(h16[11:8], h16[15:12], w16[3:0]));
                        state    <= ST_C_D3;
                    end
                    ST_C_D3: begin
                        out_data <= DATA_W'(nib_beat(INTERLACE_PROG, h16[3:0], h16[7:4]));
                        out_eop  <= 1'b1;
                        state    <= ST_V_HDR;
                    end
                    ST_V_HDR: begin
                        out_data <= DATA_W'(nib_beat(4'h0, 4'h0, PKT_VID));
                        out_sop  <= 1'b1;
                        out_eop  <= 1'b0;
                        x        <= '0;
                        y        <= '0;
                        state    <= ST_V_PIX;
                    end
                    ST_V_PIX: begin
                        if (last_out) begin
                            // Last pixel accepted: one empty slot, then next frame or idle.
                            out_valid  <= 1'b0;
                            out_sop    <= 1'b0;
                            out_eop    <= 1'b0;
                            last_out   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= enable ? ST_C_HDR : ST_IDLE;
                        end else begin
                            out_data <= DATA_W'(pixel);
                            out_sop  <= 1'b0;
                            out_eop  <= x_last && y_last;
                            if (x_last) begin
                                x <= '0;
                                if (y_last) begin
                                    y        <= '0;
                                    last_out <= 1'b1;
                                end else begin
                                    y <= y + DIM_W'(1);
                                end
                            end else begin
                                x <= x + DIM_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_y_pattern_tx.sv
// Self-checking bench for y_pattern_tx: expected beat stream per frame built from the
// packet-format rules, compared beat-by-beat on every transfer.
module tb_y_pattern_tx;

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        logic        last_pix;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [35:0] ctrl_data = '0;
    logic        ctrl_valid = 1'b0;
    logic        frame_done;
    int          rdy_mode = 0; // 0 always ready, 1 random, 2 never

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    int          beat_no = 0;

    y_pattern_tx_if #(.DATA_W(24)) vif ();

    y_pattern_tx #(
        .DATA_W     (24),
        .DIM_W      (12),
        .DEF_WIDTH  (256),
        .DEF_HEIGHT (256)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .pattern_sel      (pattern_sel),
        .control_in_data  (ctrl_data),
        .control_in_valid (ctrl_valid),
        .video_out        (vif),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        vif.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       vif.ready = 1'b1;
                1:       vif.ready = 1'($urandom_range(0, 1));
                default: vif.ready = 1'b0;
            endcase
        end
    end

    // ---------------- model ----------------
    function automatic logic [23:0] model_bar(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] model_pix(input int sel, input int px, input int py);
        case (sel)
            0: return 24'h808080;
            1: return 24'((px % 256) * 65793);
            2: return 24'((py % 256) * 65793);
            default: return model_bar((px / 32) % 8);
        endcase
    endfunction

    function automatic int nib(input int v, input int k);
        return (v >> (4 * k)) & 15;
    endfunction

    // Control beat k (1..3): symbols carry W[15:0], H[15:0] nibbles, then interlace.
    function automatic logic [23:0] model_ctrl(input int w, input int h, input int k);
        int s2, s1, s0;
        if (k == 1) begin
            s2 = nib(w, 1); s1 = nib(w, 2); s0 = nib(w, 3);
        end else if (k == 2) begin
            s2 = nib(h, 2); s1 = nib(h, 3); s0 = nib(w, 0);
        end else begin
            s2 = 3; s1 = nib(h, 0); s0 = nib(h, 1);
        end
        return 24'(s2 * 65536 + s1 * 256 + s0);
    endfunction

    function automatic beat_t mk(input logic [23:0] d, input logic s, input logic e,
                                 input logic l);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.last_pix = l;
        return b;
    endfunction

    task automatic push_frame(input int w, input int h, input int sel);
        exp_q.push_back(mk(24'h00000F, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(model_ctrl(w, h, 1), 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(model_ctrl(w, h, 2), 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(model_ctrl(w, h, 3), 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(24'h000000, 1'b1, 1'b0, 1'b0));
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) begin
                logic l;
                l = (px == w - 1) && (py == h - 1);
                exp_q.push_back(mk(model_pix(sel, px, py), 1'b0, l, l));
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic        prev_stall;
        logic        prev_last;
        logic [23:0] pd;
        logic        ps, pe;
        beat_t       e;
        logic        cur_last;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        pd = '0; ps = 1'b0; pe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_last  = 1'b0;
            end else begin
                cur_last = 1'b0;
                check("frame_done", 32'(frame_done), 32'(prev_last));
                if (prev_stall) begin
                    check("stall_valid", 32'(vif.valid), 32'd1);
                    check("stall_data", 32'(vif.data), 32'(pd));
                    check("stall_sopeop", {30'd0, vif.sop, vif.eop}, {30'd0, ps, pe});
                end
                if (vif.valid && vif.ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %h sop %0b eop %0b, expected none",
                                 vif.data, vif.sop, vif.eop);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d", beat_no),
                              {6'd0, vif.data, vif.sop, vif.eop}, {6'd0, e.data, e.sop, e.eop});
                        cur_last = e.last_pix;
                    end
                    beat_no++;
                end
                prev_stall = vif.valid && !vif.ready;
                pd = vif.data; ps = vif.sop; pe = vif.eop;
                prev_last = vif.valid && vif.ready && cur_last;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ctrl(input int w, input int h);
        @(posedge clk);
        #1;
        ctrl_data  = {12'hABC, 12'(h), 12'(w)};
        ctrl_valid = 1'b1;
        @(posedge clk);
        #1;
        ctrl_valid = 1'b0;
    endtask

    task automatic pulse_enable();
        @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < budget);
        checks++;
        if (!frame_done) begin
            errors++;
            $display("FAIL %s: frame_done not seen within %0d cycles, expected a pulse", name,
                     budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Model pins (hand-computed).
        check("model_d1_256", 32'(model_ctrl(256, 256, 1)), 32'h000100);
        check("model_d2_256", 32'(model_ctrl(256, 256, 2)), 32'h010000);
        check("model_d3_256", 32'(model_ctrl(256, 256, 3)), 32'h030000);
        check("model_d2_4x2", 32'(model_ctrl(4, 2, 2)), 32'h000004);
        check("model_d3_4x2", 32'(model_ctrl(4, 2, 3)), 32'h030200);
        check("model_ramp_x", 32'(model_pix(1, 3, 0)), 32'h030303);
        check("model_ramp_y", 32'(model_pix(2, 0, 257)), 32'h010101);
        check("model_bar", 32'(model_pix(3, 40, 0)), 32'hFFFF00);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(vif.valid), 32'd0);
        check("rst_sop", 32'(vif.sop), 32'd0);
        check("rst_eop", 32'(vif.eop), 32'd0);
        check("rst_data", 32'(vif.data), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // 1: default 256x256 grey frame.
        push_frame(256, 256, 0);
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (10) @(posedge clk);
        #1 enable = 1'b0;
        wait_done("t1_default", 70000);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // 2: 4x2 horizontal ramp.
        set_ctrl(4, 2);
        pattern_sel = 2'd1;
        push_frame(4, 2, 1);
        pulse_enable();
        wait_done("t2_ramp", 200);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // 3: random back-pressure, colour bars 64x2.
        set_ctrl(64, 2);
        pattern_sel = 2'd3;
        push_frame(64, 2, 3);
        @(negedge clk) rdy_mode = 1;
        pulse_enable();
        wait_done("t3_random", 3000);
        rdy_mode = 0;
        check("t3_queue", 32'(exp_q.size()), 32'd0);

        // 4: width and pattern changed mid-frame apply to the next frame only.
        set_ctrl(4, 2);
        pattern_sel = 2'd2;
        push_frame(4, 2, 2);
        push_frame(8, 2, 0);
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (3) @(posedge clk);
        set_ctrl(8, 2);
        pattern_sel = 2'd0;
        wait_done("t4_frame1", 200);
        enable = 1'b0;
        wait_done("t4_frame2", 200);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // 4b: control strobe coincident with the latch; also H=1.
        @(posedge clk);
        #1;
        enable     = 1'b1;
        ctrl_data  = {12'h0, 12'd1, 12'd2};
        ctrl_valid = 1'b1;
        push_frame(8, 2, 0);
        push_frame(2, 1, 0);
        @(posedge clk);
        #1 ctrl_valid = 1'b0;
        wait_done("t4b_frame1", 200);
        enable = 1'b0;
        wait_done("t4b_frame2", 200);
        check("t4b_queue", 32'(exp_q.size()), 32'd0);

        // 1x1 frame.
        set_ctrl(1, 1);
        pattern_sel = 2'd3;
        push_frame(1, 1, 3);
        pulse_enable();
        wait_done("t_1x1", 100);
        check("t_1x1_queue", 32'(exp_q.size()), 32'd0);

        // 5: W=0 selects default width; enable drops mid-frame.
        set_ctrl(0, 2);
        pattern_sel = 2'd1;
        push_frame(256, 2, 1);
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (30) @(posedge clk);
        #1 enable = 1'b0;
        wait_done("t5_def_w", 1000);
        repeat (10) begin
            @(negedge clk);
            check("t5_idle_valid", 32'(vif.valid), 32'd0);
        end
        check("t5_queue", 32'(exp_q.size()), 32'd0);

        // 6: reset during a stalled video packet.
        set_ctrl(4, 2);
        pattern_sel = 2'd0;
        push_frame(4, 2, 0);
        pulse_enable();
        repeat (8) @(posedge clk);
        @(negedge clk) rdy_mode = 2;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_valid", 32'(vif.valid), 32'd0);
        check("t6_sop", 32'(vif.sop), 32'd0);
        check("t6_eop", 32'(vif.eop), 32'd0);
        exp_q.delete();
        rdy_mode = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        set_ctrl(4, 2);
        push_frame(4, 2, 0);
        pulse_enable();
        wait_done("t6_restart", 200);
        check("t6_queue", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
